idu_decode_queue: RTL and testbench
===================================

// Module: idu_decode_queue
// PURPOSE
//  Next-gen decode stage: buffers fetched instructions in a QDEPTH-entry FIFO, decodes RV64I/RV32I
//  into a registered control bundle, and issues downstream over valid/ready.
//  A 32-entry scoreboard blocks issue on RAW hazards until the writeback port clears the register.
//  Sits between IFU and EXU; regfile read happens downstream using out_rs1/out_rs2.
// PARAMETERS
//  XLEN    64  datapath width (64 or 32); 32 makes W-ops (opcode 0x1B/0x3B) illegal
//  QDEPTH  4   instruction FIFO entries (power of 2, >=2)
// PORTS
//  clk        in   1        clock, all state on rising edge
//  rst        in   1        asynchronous, active-high reset
//  in_valid   in   1        IFU has instruction
//  in_ready   out  1        FIFO can accept (= !full && !rst)
//  in_inst    in   32       instruction word
//  in_pc      in   XLEN     instruction PC
//  out_valid  out  1        decoded bundle valid
//  out_ready  in   1        EXU accepts bundle
//  out_pc     out  XLEN     PC of issued instruction
//  out_imm    out  XLEN     sign-extended immediate (I/S/B/J/U), 0 for R-type/illegal
//  out_rs1    out  5        source 1 index
//  out_rs2    out  5        source 2 index
//  out_rd     out  5        destination index
//  out_ctrl   out  16       {ebreak,illegal,mask_type[2:0],branch_type[2:0],lui,jalr,jal,auipc,word_op,alu_bsrc,mem_write,reg_write}
//  wb_valid   in   1        writeback of wb_rd completes this cycle
//  wb_rd      in   5        register being written back
//  flush      in   1        sync: discard FIFO and output bundle
// BEHAVIOUR
//  Reset: FIFO empty, out_valid=0, out_pc/out_imm/out_rs*/out_rd/out_ctrl=0, scoreboard all clear.
//  Push: in_valid&&in_ready writes {pc,inst} at tail; no push when full (in_ready=0 while full).
//  Decode: combinational from FIFO head; result captured in output register at issue.
//  Issue when head present && (!out_valid || out_ready) && !hazard && !flush; pops head.
//  Hazard: rs1 used && busy[rs1], or rs2 used && busy[rs2]; rs1 used by all except U/J;
//   rs2 used by R/S/B. busy[0] is constant 0. Busy is checked from registered state (no bypass).
//  Issue of reg_write instr with rd!=0 sets busy[rd]. wb_valid clears busy[wb_rd];
//   same-cycle set and clear of the same rd: set wins.
//  Latency: push at edge N into empty FIFO -> out_valid high after edge N+1 (min 2 edges end-to-end).
//  Throughput: 1 issue/cycle when out_ready=1 and no hazards.
//  Hold: while out_valid&&!out_ready, all out_* stable.
//  out_valid drops after out_ready handshake unless a new issue occurs same edge.
//  flush: FIFO emptied, out_valid=0, same-cycle push and issue suppressed; scoreboard untouched
//   (in-flight writers still write back).
//  Decode rules: branch_type=funct3 for B, else 3'b010 (never taken); mask_type=funct3;
//   word_op=inst[3] for 0x1B/0x3B only; alu_bsrc for U/S/I/load/jalr; jalr requires funct3=0.
//  illegal: unknown opcode, jalr funct3!=0, W-op when XLEN=32; forces reg_write=0, mem_write=0, imm=0;
//   still issued so EXU can trap.
//  ebreak: inst==32'h0010_0073; issued with reg_write=0.
//  Reset mid-operation: all state cleared immediately; in-flight bundle lost.
// TESTING
//  reset then push addi x1,x0,5 (0x00500093) pc=0x8000_0000 -> out_valid after 2 edges, imm=5, rd=1, reg_write=1
//  push addi x1 then add x2,x1,x1; no wb -> second held (out_valid=0 after first consumed); wb_valid rd=1 -> issues next+1 cycle
//  out_ready=0, push 5 instrs with QDEPTH=4 -> in_ready=0 after 4 in FIFO + 1 held; output stable; release drains in order
//  push beq x1,x2,-8 -> imm=0xFFFF_FFFF_FFFF_FFF8, branch_type=000, reg_write=0; push jalr funct3=1 -> illegal=1
//  XLEN=32: push addiw (0x0010009B) -> illegal=1; push 0x00100073 -> ebreak=1
//  flush with FIFO 3 full, out_valid=1, in_valid=1 -> next cycle FIFO empty, out_valid=0, busy bits unchanged

Source files
------------

// File: rtl/idu_decode_queue_if.sv
// Handshake bundle between the IFU (instruction push), the decode queue,
// the EXU (decoded bundle) and the writeback port.
interface idu_decode_queue_if #(
  parameter int XLEN = 64
);
  // IFU -> decode queue
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;

  // decode queue -> EXU
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_imm;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [15:0]     out_ctrl;

  // writeback and pipeline control
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic            flush;

  // Environment side: drives instructions, accepts bundles, reports writebacks.
  modport master (
    output in_valid, in_inst, in_pc, out_ready, wb_valid, wb_rd, flush,
    input  in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd, out_ctrl
  );

  // Decode queue side.
  modport slave (
    input  in_valid, in_inst, in_pc, out_ready, wb_valid, wb_rd, flush,
    output in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd, out_ctrl
  );
endinterface

// File: rtl/idu_decode_queue.sv
// Decode stage: instruction FIFO, RV64I/RV32I decoder, RAW scoreboard and a
// registered output bundle issued over valid/ready.
module idu_decode_queue #(
  parameter int XLEN   = 64,
  parameter int QDEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  idu_decode_queue_if.slave bus
);

  localparam int AW = $clog2(QDEPTH);

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_IMM32  = 7'h1B;
  localparam logic [6:0] OP_REG32  = 7'h3B;
  localparam logic [6:0] OP_FENCE  = 7'h0F;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

  // ---------------------------------------------------------------------------
  // Instruction FIFO (extra pointer bit distinguishes full from empty)
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] pc_mem   [QDEPTH];
  logic [31:0]     inst_mem [QDEPTH];
  logic [AW:0]     head_reg;
  logic [AW:0]     tail_reg;
  logic            fifo_empty;
  logic            fifo_full;
  logic            push;
  logic            issue;

  assign fifo_empty = (head_reg == tail_reg);
  assign fifo_full  = (head_reg[AW] != tail_reg[AW]) &&
                      (head_reg[AW-1:0] == tail_reg[AW-1:0]);

  assign bus.in_ready = !fifo_full && !rst;
  assign push         = bus.in_valid && !fifo_full && !bus.flush;

  // Storage write at the tail; head is read asynchronously so decode can
  // issue the cycle after a push.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_reg[AW-1:0]]   <= bus.in_pc;
      inst_mem[tail_reg[AW-1:0]] <= bus.in_inst;
    end
  end

  // Pointer update: flush empties the queue, otherwise push/pop independently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg <= '0;
      tail_reg <= '0;
    end else if (bus.flush) begin
      head_reg <= '0;
      tail_reg <= '0;
    end else begin
      if (push)  tail_reg <= tail_reg + 1'b1;
      if (issue) head_reg <= head_reg + 1'b1;
    end
  end

  logic [31:0]     head_inst;
  logic [XLEN-1:0] head_pc;

  assign head_inst = inst_mem[head_reg[AW-1:0]];
  assign head_pc   = pc_mem[head_reg[AW-1:0]];

  // ---------------------------------------------------------------------------
  // Decoder
  // ---------------------------------------------------------------------------
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  d_rs1;
  logic [4:0]  d_rs2;
  logic [4:0]  d_rd;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign opcode = head_inst[6:0];
  assign funct3 = head_inst[14:12];
  assign d_rs1  = head_inst[19:15];
  assign d_rs2  = head_inst[24:20];
  assign d_rd   = head_inst[11:7];

  assign imm_i = {{20{head_inst[31]}}, head_inst[31:20]};
  assign imm_s = {{20{head_inst[31]}}, head_inst[31:25], head_inst[11:7]};
  assign imm_b = {{19{head_inst[31]}}, head_inst[31], head_inst[7],
                  head_inst[30:25], head_inst[11:8], 1'b0};
  assign imm_u = {head_inst[31:12], 12'b0};
  assign imm_j = {{11{head_inst[31]}}, head_inst[31], head_inst[19:12],
                  head_inst[20], head_inst[30:21], 1'b0};

  logic [31:0] d_imm32;
  logic        d_ebreak;
  logic        d_illegal;
  logic [2:0]  d_branch_type;
  logic        d_lui;
  logic        d_jalr;
  logic        d_jal;
  logic        d_auipc;
  logic        d_word_op;
  logic        d_alu_bsrc;
  logic        d_mem_write;
  logic        d_reg_write;
  logic        rs1_used;
  logic        rs2_used;

  // Opcode decode into control fields; illegal instructions keep their
  // decoded flags for the trap handler but never write state.
  always_comb begin
    d_imm32       = '0;
    d_ebreak      = 1'b0;
    d_illegal     = 1'b0;
    d_branch_type = 3'b010;
    d_lui         = 1'b0;
    d_jalr        = 1'b0;
    d_jal         = 1'b0;
    d_auipc       = 1'b0;
    d_word_op     = 1'b0;
    d_alu_bsrc    = 1'b0;
    d_mem_write   = 1'b0;
    d_reg_write   = 1'b0;
    rs1_used      = 1'b1;
    rs2_used      = 1'b0;
    case (opcode)
      OP_LUI: begin
        d_lui       = 1'b1;
        d_reg_write = 1'b1;
        d_alu_bsrc  = 1'b1;
        rs1_used    = 1'b0;
        d_imm32     = imm_u;
      end
      OP_AUIPC: begin
        d_auipc     = 1'b1;
        d_reg_write = 1'b1;
        d_alu_bsrc  = 1'b1;
        rs1_used    = 1'b0;
        d_imm32     = imm_u;
      end
      OP_JAL: begin
        d_jal       = 1'b1;
        d_reg_write = 1'b1;
        rs1_used    = 1'b0;
        d_imm32     = imm_j;
      end
      OP_JALR: begin
        d_jalr      = 1'b1;
        d_reg_write = 1'b1;
        d_alu_bsrc  = 1'b1;
        d_imm32     = imm_i;
        d_illegal   = (funct3 != 3'b000);
      end
      OP_BRANCH: begin
        d_branch_type = funct3;
        rs2_used      = 1'b1;
        d_imm32       = imm_b;
      end
      OP_LOAD: begin
        d_reg_write = 1'b1;
        d_alu_bsrc  = 1'b1;
        d_imm32     = imm_i;
      end
      OP_STORE: begin
        d_mem_write = 1'b1;
        d_alu_bsrc  = 1'b1;
        rs2_used    = 1'b1;
        d_imm32     = imm_s;
      end
      OP_IMM: begin
        d_reg_write = 1'b1;
        d_alu_bsrc  = 1'b1;
        d_imm32     = imm_i;
      end
      OP_REG: begin
        d_reg_write = 1'b1;
        rs2_used    = 1'b1;
      end
      OP_IMM32: begin
        d_reg_write = 1'b1;
        d_alu_bsrc  = 1'b1;
        d_word_op   = head_inst[3];
        d_imm32     = imm_i;
        d_illegal   = (XLEN == 32);
      end
      OP_REG32: begin
        d_reg_write = 1'b1;
        rs2_used    = 1'b1;
        d_word_op   = head_inst[3];
        d_illegal   = (XLEN == 32);
      end
      OP_FENCE: begin
        d_imm32 = imm_i;
      end
      OP_SYSTEM: begin
        d_imm32  = imm_i;
        d_ebreak = (head_inst == EBREAK_INST);
      end
      default: begin
        d_illegal = 1'b1;
      end
    endcase
    if (d_illegal) begin
      d_reg_write = 1'b0;
      d_mem_write = 1'b0;
      d_imm32     = '0;
    end
  end

  logic [XLEN-1:0] d_imm;
  logic [15:0]     d_ctrl;

  assign d_imm  = XLEN'($signed(d_imm32));
  assign d_ctrl = {d_ebreak, d_illegal, funct3, d_branch_type, d_lui, d_jalr,
                   d_jal, d_auipc, d_word_op, d_alu_bsrc, d_mem_write, d_reg_write};

  // ---------------------------------------------------------------------------
  // Scoreboard and issue
  // ---------------------------------------------------------------------------
  logic [31:0] busy_reg;
  logic [31:0] busy_next;
  logic        hazard;
  logic        out_valid_reg;

  assign hazard = (rs1_used && busy_reg[d_rs1]) || (rs2_used && busy_reg[d_rs2]);
  assign issue  = !fifo_empty && (!out_valid_reg || bus.out_ready) && !hazard && !bus.flush;

  // Per-register busy: an issuing writer sets it (winning over a same-cycle
  // writeback), a writeback clears it; x0 is never busy.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign busy_next[gi] = 1'b0;
      end else begin : g_reg
        assign busy_next[gi] = (issue && d_reg_write && (d_rd == 5'(gi))) ? 1'b1 :
                               (bus.wb_valid && (bus.wb_rd == 5'(gi))) ? 1'b0 :
                               busy_reg[gi];
      end
    end
  endgenerate

  // Scoreboard state; flush leaves it alone because in-flight writers still write back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_reg <= '0;
    else     busy_reg <= busy_next;
  end

  // ---------------------------------------------------------------------------
  // Output bundle register
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] out_pc_reg;
  logic [XLEN-1:0] out_imm_reg;
  logic [4:0]      out_rs1_reg;
  logic [4:0]      out_rs2_reg;
  logic [4:0]      out_rd_reg;
  logic [15:0]     out_ctrl_reg;

  // Capture the decoded head on issue; hold while stalled; drop valid once consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_pc_reg    <= '0;
      out_imm_reg   <= '0;
      out_rs1_reg   <= '0;
      out_rs2_reg   <= '0;
      out_rd_reg    <= '0;
      out_ctrl_reg  <= '0;
    end else if (bus.flush) begin
      out_valid_reg <= 1'b0;
    end else if (issue) begin
      out_valid_reg <= 1'b1;
      out_pc_reg    <= head_pc;
      out_imm_reg   <= d_imm;
      out_rs1_reg   <= d_rs1;
      out_rs2_reg   <= d_rs2;
      out_rd_reg    <= d_rd;
      out_ctrl_reg  <= d_ctrl;
    end else if (bus.out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_pc    = out_pc_reg;
  assign bus.out_imm   = out_imm_reg;
  assign bus.out_rs1   = out_rs1_reg;
  assign bus.out_rs2   = out_rs2_reg;
  assign bus.out_rd    = out_rd_reg;
  assign bus.out_ctrl  = out_ctrl_reg;

endmodule

// File: tb/tb_idu_decode_queue.sv
// Directed bench for idu_decode_queue: 64-bit instance driven through a
// scoreboard of expected bundles, plus a 32-bit instance for W-op/ebreak decode.
module tb_idu_decode_queue;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [15:0] ctrl;
  } bundle_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  bundle_t exp_q[$];
  bundle_t drv_exp;

  idu_decode_queue_if #(.XLEN(64)) bus64 ();
  idu_decode_queue_if #(.XLEN(32)) bus32 ();

  idu_decode_queue #(.XLEN(64), .QDEPTH(4)) dut64 (.clk(clk), .rst(rst), .bus(bus64));
  idu_decode_queue #(.XLEN(32), .QDEPTH(4)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic bundle_t mk(input logic [63:0] pc, input logic [31:0] inst,
                                 input logic [63:0] imm, input logic [15:0] ctrl);
    bundle_t b;
    b.pc   = pc;
    b.imm  = imm;
    b.rs1  = inst[19:15];
    b.rs2  = inst[24:20];
    b.rd   = inst[11:7];
    b.ctrl = ctrl;
    return b;
  endfunction

  task automatic send(input logic [63:0] pc, input logic [31:0] inst,
                      input logic [63:0] imm, input logic [15:0] ctrl);
    bus64.in_valid = 1'b1;
    bus64.in_pc    = pc;
    bus64.in_inst  = inst;
    drv_exp        = mk(pc, inst, imm, ctrl);
  endtask

  task automatic check_out();
    bundle_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_out", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk("out_pc", bus64.out_pc, e.pc);
      chk("out_imm", bus64.out_imm, e.imm);
      chk("out_rs1", 64'(bus64.out_rs1), 64'(e.rs1));
      chk("out_rs2", 64'(bus64.out_rs2), 64'(e.rs2));
      chk("out_rd", 64'(bus64.out_rd), 64'(e.rd));
      chk("out_ctrl", 64'(bus64.out_ctrl), 64'(e.ctrl));
      $display("issue pc=%h ctrl=%h rd=%0d", bus64.out_pc, bus64.out_ctrl, bus64.out_rd);
    end
  endtask

  // One clock: account for handshakes that fire at the coming edge, then
  // advance to the next falling edge where outputs are sampled.
  task automatic tick();
    if (bus64.out_valid && bus64.out_ready && !bus64.flush) check_out();
    if (bus64.in_valid && bus64.in_ready && !bus64.flush) exp_q.push_back(drv_exp);
    if (bus64.flush) exp_q.delete();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 12 && (exp_q.size() != 0 || bus64.out_valid); i++) tick();
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [2:0]  kk;
    logic [31:0] inst;

    bus64.in_valid = 1'b0; bus64.in_inst = '0; bus64.in_pc = '0;
    bus64.out_ready = 1'b1; bus64.wb_valid = 1'b0; bus64.wb_rd = '0; bus64.flush = 1'b0;
    bus32.in_valid = 1'b0; bus32.in_inst = '0; bus32.in_pc = '0;
    bus32.out_ready = 1'b1; bus32.wb_valid = 1'b0; bus32.wb_rd = '0; bus32.flush = 1'b0;
    drv_exp = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(bus64.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus64.in_ready), 64'd0);
    chk("rst_out_pc", bus64.out_pc, 64'd0);
    chk("rst_out_imm", bus64.out_imm, 64'd0);
    chk("rst_out_ctrl", 64'(bus64.out_ctrl), 64'd0);
    chk("rst_out_rd", 64'(bus64.out_rd), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 64'(bus64.in_ready), 64'd1);
    chk("idle_in_ready32", 64'(bus32.in_ready), 64'd1);

    // Latency: addi x1,x0,5
    send(64'h8000_0000, 32'h0050_0093, 64'd5, 16'h0205);
    tick();
    bus64.in_valid = 1'b0;
    chk("lat_edge1_valid", 64'(bus64.out_valid), 64'd0);
    tick();
    chk("lat_edge2_valid", 64'(bus64.out_valid), 64'd1);
    chk("lat_imm", bus64.out_imm, 64'd5);
    chk("lat_rd", 64'(bus64.out_rd), 64'd1);
    chk("lat_reg_write", 64'(bus64.out_ctrl[0]), 64'd1);
    drain("drain_lat");

    // RAW hazard: addi x1 then add x2,x1,x1 held until x1 writes back
    send(64'h8000_0010, 32'h0050_0093, 64'd5, 16'h0205);
    tick();
    send(64'h8000_0014, 32'h0010_8133, 64'd0, 16'h0201);
    tick();
    bus64.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hazard_hold", 64'(bus64.out_valid), 64'd0);
    end
    bus64.wb_valid = 1'b1;
    bus64.wb_rd    = 5'd1;
    tick();
    bus64.wb_valid = 1'b0;
    chk("wb_clear_edge", 64'(bus64.out_valid), 64'd0);
    tick();
    chk("wb_issue_next", 64'(bus64.out_valid), 64'd1);
    drain("drain_raw");
    bus64.wb_valid = 1'b1;
    bus64.wb_rd    = 5'd2;
    tick();
    bus64.wb_valid = 1'b0;

    // Branch imm, illegal jalr, legal addiw on RV64
    send(64'h8000_0020, 32'hFE20_8CE3, 64'hFFFF_FFFF_FFFF_FFF8, 16'h0000);
    tick();
    send(64'h8000_0024, 32'h0040_11E7, 64'd0, 16'h4A44);
    tick();
    send(64'h8000_0028, 32'h0010_009B, 64'd1, 16'h020D);
    tick();
    bus64.in_valid = 1'b0;
    drain("drain_decode");

    // Back-pressure: 5 lui pushed while EXU stalls -> 1 held + 4 queued
    bus64.out_ready = 1'b0;
    for (int k = 3; k < 8; k++) begin
      kk   = 3'(k);
      inst = (32'(k) << 12) | (32'(k) << 7) | 32'h37;
      send(64'h8000_0100 + 64'(4 * k), inst, 64'(k) << 12,
           {2'b00, kk, 3'b010, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1});
      tick();
    end
    chk("full_in_ready", 64'(bus64.in_ready), 64'd0);
    send(64'h8000_0200, 32'h0000_0013, 64'd0, 16'h0205);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_valid", 64'(bus64.out_valid), 64'd1);
      chk("hold_pc", bus64.out_pc, 64'h8000_010C);
      chk("hold_imm", bus64.out_imm, 64'h3000);
    end
    bus64.in_valid  = 1'b0;
    bus64.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("thru_valid", 64'(bus64.out_valid), 64'd1);
      tick();
    end
    chk("thru_done", 64'(bus64.out_valid), 64'd0);
    chk("thru_q", 64'(exp_q.size()), 64'd0);

    // Flush with 3 queued, bundle valid and a push in the same cycle
    bus64.out_ready = 1'b0;
    for (int k = 1; k < 5; k++) begin
      send(64'h8000_0300 + 64'(4 * k), (32'(k) << 20) | 32'h13, 64'(k), 16'h0205);
      tick();
    end
    chk("pre_flush_valid", 64'(bus64.out_valid), 64'd1);
    send(64'h8000_0320, 32'h0050_0013, 64'd5, 16'h0205);
    bus64.flush = 1'b1;
    tick();
    bus64.flush    = 1'b0;
    bus64.in_valid = 1'b0;
    chk("flush_out_valid", 64'(bus64.out_valid), 64'd0);
    chk("flush_in_ready", 64'(bus64.in_ready), 64'd1);
    bus64.out_ready = 1'b1;
    tick();
    tick();
    chk("flush_empty", 64'(bus64.out_valid), 64'd0);
    // x5 was set busy by lui x5 before the flush; add x10,x5,x0 must wait
    send(64'h8000_0400, 32'h0002_8533, 64'd0, 16'h0201);
    tick();
    bus64.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush_busy_kept", 64'(bus64.out_valid), 64'd0);
    end
    bus64.wb_valid = 1'b1;
    bus64.wb_rd    = 5'd5;
    tick();
    bus64.wb_valid = 1'b0;
    drain("drain_x10");

    // RV32 instance: addiw illegal, ebreak
    bus32.in_valid = 1'b1;
    bus32.in_pc    = 32'h0000_0100;
    bus32.in_inst  = 32'h0010_009B;
    tick();
    bus32.in_valid = 1'b0;
    tick();
    chk("rv32_addiw_valid", 64'(bus32.out_valid), 64'd1);
    chk("rv32_addiw_ctrl", 64'(bus32.out_ctrl), 64'h420C);
    chk("rv32_addiw_imm", 64'(bus32.out_imm), 64'd0);
    $display("rv32 issue pc=%h ctrl=%h", bus32.out_pc, bus32.out_ctrl);
    bus32.in_valid = 1'b1;
    bus32.in_pc    = 32'h0000_0104;
    bus32.in_inst  = 32'h0010_0073;
    tick();
    bus32.in_valid = 1'b0;
    tick();
    chk("rv32_ebreak_valid", 64'(bus32.out_valid), 64'd1);
    chk("rv32_ebreak_ctrl", 64'(bus32.out_ctrl), 64'h8200);
    chk("rv32_ebreak_pc", 64'(bus32.out_pc), 64'h104);
    $display("rv32 issue pc=%h ctrl=%h", bus32.out_pc, bus32.out_ctrl);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
